// File: rtl/key_entry_ctrl_pkg.sv
// calc_pkg: key classes, operator codes and controller states shared by key_entry_ctrl
package calc_pkg;
    typedef enum logic [1:0] {
        KC_DIGIT = 2'b00,
        KC_OP    = 2'b01,
        KC_EQ    = 2'b10
    } key_class_t;
    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_SIGN = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_CE   = 3'b110;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_APPLY,
        S_ACK,
        S_ISSUE,
        S_WAIT_CALC
    } state_t;
    function automatic logic is_arith(input logic [2:0] op);
        return op == OP_ADD || op == OP_SUB || op == OP_MUL;
    endfunction
endpackage

// File: rtl/key_entry_ctrl_if.sv
// key_entry_ctrl_if: keypad handshake, arithmetic-unit transaction and display status bundle
interface key_entry_ctrl_if #(parameter int WIDTH = 16);
    logic             KeyRdy;
    logic             KeyRd;
    logic [1:0]       KeyClass;
    logic [3:0]       KeyNumber;
    logic [2:0]       KeyOp;
    logic             CalcStart;
    logic [WIDTH-1:0] CalcOpA;
    logic [WIDTH-1:0] CalcOpB;
    logic [2:0]       CalcOp;
    logic             CalcDone;
    logic [WIDTH-1:0] CalcResult;
    logic [WIDTH-1:0] Display;
    logic [2:0]       PendingOp;
    logic             Error;
    modport slave (
        input  KeyRdy, KeyClass, KeyNumber, KeyOp, CalcDone, CalcResult,
        output KeyRd, CalcStart, CalcOpA, CalcOpB, CalcOp, Display, PendingOp, Error
    );
    modport master (
        output KeyRdy, KeyClass, KeyNumber, KeyOp, CalcDone, CalcResult,
        input  KeyRd, CalcStart, CalcOpA, CalcOpB, CalcOp, Display, PendingOp, Error
    );
endinterface

// File: rtl/key_entry_ctrl_entry_accum.sv
// entry_accum: decimal shift-in (mag*10 + digit) with overflow detect; ENTRY_SATURATE_EN clamps instead of rejecting
module entry_accum #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_mag,
    input  logic [3:0]       i_digit,
    output logic [WIDTH-1:0] o_mag,
    output logic             o_err
);
    localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
    logic [WIDTH+3:0] w_nx;
    logic             w_ovf;
    assign w_nx  = ({4'b0, i_mag} << 3) + ({4'b0, i_mag} << 1) + {{WIDTH{1'b0}}, i_digit};
    assign w_ovf = w_nx > {4'b0, MAX};
`ifdef ENTRY_SATURATE_EN
    assign o_mag = w_ovf ? MAX : w_nx[WIDTH-1:0];
    assign o_err = 1'b0;
`else
    assign o_mag = w_ovf ? i_mag : w_nx[WIDTH-1:0];
    assign o_err = w_ovf;
`endif
endmodule

// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: keypad consumer that builds a signed operand and runs start/done calc transactions.
// Build option: define ENTRY_SATURATE_EN to clamp digit overflow instead of flagging Error.
module key_entry_ctrl
    import calc_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int DONE_TIMEOUT = 255
) (
    input  logic           Clock,
    input  logic           Reset,
    key_entry_ctrl_if.slave bus
);
    localparam int CW = $clog2(DONE_TIMEOUT + 1);
    state_t           r_state, w_state_nxt;
    logic [1:0]       r_cls;
    logic [3:0]       r_num;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_mag, w_mag_nxt, r_opa, w_opa_nxt, r_ca, w_ca_nxt, r_cb, w_cb_nxt, r_disp;
    logic [WIDTH-1:0] w_entry, w_acc_in, w_acc_mag, w_res_mag;
    logic             r_neg, w_neg_nxt, r_fresh, w_fresh_nxt, r_err, w_err_nxt, w_acc_err;
    logic [2:0]       r_pend, w_pend_nxt, r_cop, w_cop_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;

    assign w_entry   = r_neg ? -r_mag : r_mag;
    assign w_res_mag = bus.CalcResult[WIDTH-1] ? -bus.CalcResult : bus.CalcResult;
    assign w_acc_in  = r_fresh ? '0 : r_mag;

    entry_accum #(.WIDTH(WIDTH)) u_acc (
        .i_mag  (w_acc_in),
        .i_digit(r_num),
        .o_mag  (w_acc_mag),
        .o_err  (w_acc_err)
    );

    assign bus.KeyRd     = r_state != S_IDLE;
    assign bus.CalcStart = r_state == S_ISSUE;
    assign bus.CalcOpA   = r_ca;
    assign bus.CalcOpB   = r_cb;
    assign bus.CalcOp    = r_cop;
    assign bus.Display   = r_disp;
    assign bus.PendingOp = r_pend;
    assign bus.Error     = r_err;

    // Sample key fields only while idle so a held key cannot change mid-transaction
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_cls <= '0;
            r_num <= '0;
            r_op  <= '0;
        end else if (r_state == S_IDLE && bus.KeyRdy) begin
            r_cls <= bus.KeyClass;
            r_num <= bus.KeyNumber;
            r_op  <= bus.KeyOp;
        end
    end

    // Next-state and datapath updates for one key transaction
    always_comb begin
        w_state_nxt = r_state;
        w_mag_nxt   = r_mag;
        w_neg_nxt   = r_neg;
        w_opa_nxt   = r_opa;
        w_fresh_nxt = r_fresh;
        w_pend_nxt  = r_pend;
        w_err_nxt   = r_err;
        w_ca_nxt    = r_ca;
        w_cb_nxt    = r_cb;
        w_cop_nxt   = r_cop;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE:    w_state_nxt = bus.KeyRdy ? S_CAPTURE : S_IDLE;
            S_CAPTURE: w_state_nxt = S_APPLY;
            S_APPLY: begin
                w_state_nxt = S_ACK;
                if (r_cls == KC_DIGIT && r_num <= 4'd9) begin
                    w_mag_nxt   = w_acc_mag;
                    w_neg_nxt   = r_neg & ~r_fresh;
                    w_fresh_nxt = 1'b0;
                    w_err_nxt   = r_err | w_acc_err;
                end else if (r_cls == KC_OP && r_op == OP_SIGN) begin
                    w_neg_nxt = (r_mag != '0) ? ~r_neg : r_neg;
                end else if (r_cls == KC_OP && r_op == OP_CE) begin
                    w_mag_nxt   = '0;
                    w_neg_nxt   = 1'b0;
                    w_fresh_nxt = 1'b1;
                    w_pend_nxt  = OP_NONE;
                    w_err_nxt   = 1'b0;
                end else if (r_cls == KC_OP && is_arith(r_op)) begin
                    w_opa_nxt   = r_fresh ? r_opa : w_entry;
                    w_pend_nxt  = r_op;
                    w_fresh_nxt = 1'b1;
                end else if (r_cls == KC_EQ && r_pend == OP_NONE) begin
                    w_fresh_nxt = 1'b1;
                end else if (r_cls == KC_EQ) begin
                    w_ca_nxt    = r_opa;
                    w_cb_nxt    = w_entry;
                    w_cop_nxt   = r_pend;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT_CALC;
            end
            S_WAIT_CALC: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (bus.CalcDone) begin
                    w_mag_nxt   = w_res_mag;
                    w_neg_nxt   = bus.CalcResult[WIDTH-1];
                    w_opa_nxt   = bus.CalcResult;
                    w_pend_nxt  = OP_NONE;
                    w_fresh_nxt = 1'b1;
                    w_state_nxt = S_ACK;
                end else if (r_cnt == CW'(DONE_TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_pend_nxt  = OP_NONE;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK:   w_state_nxt = bus.KeyRdy ? S_ACK : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and datapath registers; Display follows the signed entry being stored
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_mag   <= '0;
            r_neg   <= 1'b0;
            r_opa   <= '0;
            r_fresh <= 1'b1;
            r_pend  <= OP_NONE;
            r_err   <= 1'b0;
            r_ca    <= '0;
            r_cb    <= '0;
            r_cop   <= OP_NONE;
            r_cnt   <= '0;
            r_disp  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mag   <= w_mag_nxt;
            r_neg   <= w_neg_nxt;
            r_opa   <= w_opa_nxt;
            r_fresh <= w_fresh_nxt;
            r_pend  <= w_pend_nxt;
            r_err   <= w_err_nxt;
            r_ca    <= w_ca_nxt;
            r_cb    <= w_cb_nxt;
            r_cop   <= w_cop_nxt;
            r_cnt   <= w_cnt_nxt;
            r_disp  <= w_neg_nxt ? -w_mag_nxt : w_mag_nxt;
        end
    end
endmodule
